// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - WIDTH-bit registered ALU with valid/ready handshakes
// Optional SEQ_ALU_MUL_EN builds opcode 101 as a WIDTH-cycle shift-add multiply.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       aluctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             e
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             e_q, e_d;
  logic             accept;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] op_d;
  logic             op_e;

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign e         = e_q;

  // Single-cycle results are computed straight from the inputs and registered on accept.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    op_d = '0;
    op_e = 1'b0;
    case (aluctr)
      3'b000:  begin op_d = sum[WIDTH-1:0];  op_e = sum[WIDTH];  end
      3'b001:  op_d = a & b;
      3'b010:  op_d = ~(a | b);
      3'b011:  op_d = a ^ b;
      3'b100:  begin op_d = diff[WIDTH-1:0]; op_e = diff[WIDTH]; end
      default: begin op_d = '0; op_e = 1'b0; end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    e_d     = e_q;
`ifdef SEQ_ALU_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          if (aluctr == 3'b101) begin
            state_d  = CALC;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
          end else begin
            state_d = DONE;
            d_d     = op_d;
            e_d     = op_e;
          end
`else
          state_d = DONE;
          d_d     = op_d;
          e_d     = op_e;
`endif
        end
      end
`ifdef SEQ_ALU_MUL_EN
      CALC: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          d_d     = acc_step[WIDTH-1:0];
          e_d     = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      d_q      <= '0;
      e_q      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      e_q      <= e_d;
`ifdef SEQ_ALU_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=8)
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic [2:0] aluctr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       e;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .aluctr(aluctr),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .e(e)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation, waits for out_valid and checks latency/result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] aa,
                        input logic [7:0] bb, input logic c, input logic [7:0] exp_d,
                        input logic exp_e, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    aluctr = op; a = aa; b = bb; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~aa; b = ~bb; cin = ~c; aluctr = 3'b001;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_d"}, {24'd0, d}, {24'd0, exp_d});
    check({tag, "_e"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  // With out_ready high in DONE: one edge to IDLE, result held, in_ready back.
  task automatic handoff(input string tag, input logic [7:0] exp_d, input logic exp_e);
    out_ready = 1'b1;
    tick();
    check({tag, "_ho_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ho_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_ho_d"}, {24'd0, d, e}, {24'd0, exp_d, exp_e});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = '0; b = '0; cin = 1'b0; aluctr = '0; out_ready = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_de", {23'd0, d, e}, 32'd0);

    // ADD with carry out
    run_op("add", 3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1);
    handoff("add", 8'h01, 1'b1);

    // SUB borrow and no-borrow
    run_op("sub1", 3'b100, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1);
    handoff("sub1", 8'hFE, 1'b1);
    run_op("sub2", 3'b100, 8'h07, 8'h05, 1'b1, 8'h01, 1'b0, 1);
    handoff("sub2", 8'h01, 1'b0);

    // Logic ops
    run_op("and", 3'b001, 8'hC3, 8'h5A, 1'b1, 8'h42, 1'b0, 1);
    handoff("and", 8'h42, 1'b0);
    run_op("nor", 3'b010, 8'hC3, 8'h5A, 1'b0, 8'h24, 1'b0, 1);
    handoff("nor", 8'h24, 1'b0);
    run_op("xor", 3'b011, 8'hC3, 8'h5A, 1'b0, 8'h99, 1'b0, 1);
    handoff("xor", 8'h99, 1'b0);

    // XOR with consumer stalling 5 cycles
    out_ready = 1'b0;
    run_op("xor_st", 3'b011, 8'hC3, 8'h5A, 1'b0, 8'h99, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_de", {23'd0, d, e}, {23'd0, 8'h99, 1'b0});
    end
    handoff("xor_st", 8'h99, 1'b0);

    // Multiply (or reserved behaviour of 101 when not built)
`ifdef SEQ_ALU_MUL_EN
    run_op("mul1", 3'b101, 8'd15, 8'd17, 1'b1, 8'hFF, 1'b0, 9);
    handoff("mul1", 8'hFF, 1'b0);
    run_op("mul2", 3'b101, 8'd16, 8'd16, 1'b0, 8'h00, 1'b1, 9);
    handoff("mul2", 8'h00, 1'b1);
    // reset at CALC cycle 4
    aluctr = 3'b101; a = 8'd15; b = 8'd17; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("calc_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstc_valid", {31'd0, out_valid}, 32'd0);
    check("rstc_ready", {31'd0, in_ready}, 32'd1);
    check("rstc_de", {23'd0, d, e}, 32'd0);
    run_op("mul3", 3'b101, 8'd15, 8'd17, 1'b0, 8'hFF, 1'b0, 9);
    handoff("mul3", 8'hFF, 1'b0);
`else
    run_op("mul_off", 3'b101, 8'd15, 8'd17, 1'b0, 8'h00, 1'b0, 1);
    handoff("mul_off", 8'h00, 1'b0);
`endif

    // Reset in DONE with out_ready low; in_valid ignored during reset
    out_ready = 1'b0;
    run_op("add_r", 3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    check("rstd_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rstd_valid", {31'd0, out_valid}, 32'd0);
    check("rstd_ready", {31'd0, in_ready}, 32'd1);
    check("rstd_de", {23'd0, d, e}, 32'd0);
    out_ready = 1'b1;
    run_op("add_after", 3'b000, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1);
    handoff("add_after", 8'h46, 1'b0);

    // Reserved opcodes
    run_op("rsv110", 3'b110, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1);
    handoff("rsv110", 8'h00, 1'b0);
    run_op("rsv111", 3'b111, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1);
    handoff("rsv111", 8'h00, 1'b0);

    // in_valid held through DONE: no accept until after handoff
    out_ready = 1'b0;
    aluctr = 3'b111; a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    aluctr = 3'b000; a = 8'h01; b = 8'h01; cin = 1'b0;
    tick();
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("hold_de", {23'd0, d, e}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("hold_ho_valid", {31'd0, out_valid}, 32'd0);
    check("hold_ho_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("hold_next_valid", {31'd0, out_valid}, 32'd1);
    check("hold_next_de", {23'd0, d, e}, {23'd0, 8'h02, 1'b0});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
